fpdec: RTL and testbench
========================

Name: fpdec

Overview:
- Sequential floating-point-to-linear decoder; the inverse of the 12-bit linear-to-FP converter (fpcvt).
- Takes a sign/exponent/mantissa triple (s, e, f) and produces the 12-bit two's-complement value d = (s ? -1 : 1) * (f << e).
- Uses an iterative one-bit-per-cycle shifter with valid/ready handshakes on both sides.
- Sits downstream of fpcvt in the lab datapath, so round-trip checks run in hardware.

Parameters:
- W_D, 12, width of linear output d (two's complement).
- W_E, 3, exponent width.
- W_F, 4, mantissa width. Legality: (2^W_F-1) << (2^W_E-1) < 2^(W_D-1). Defaults give 1920 < 2048.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  s/e/f are valid.
- in_ready  output  1  decoder can accept; high only in IDLE.
- s  input  1  sign (1 = negative).
- e  input  W_E  exponent (shift amount).
- f  input  W_F  mantissa.
- out_valid  output  1  d/nonnorm are valid.
- out_ready  input  1  consumer accepts d.
- d  output  W_D  decoded two's-complement value.
- nonnorm  output  1  input was non-normalized (e != 0 and f[W_F-1] == 0).

Behaviour:
- Reset (async, rst=1): state=IDLE; d=0; nonnorm=0; out_valid=0; in_ready=1 (combinational from state); internal mag=0, cnt=0, sgn=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: latch sgn=s, mag=zero-extend(f) to W_D-1 bits, cnt=e, nonnorm_r=(e!=0 && !f[W_F-1]); go to SHIFT.
- SHIFT: in_ready=0, out_valid=0.
  - If cnt!=0: mag<=mag<<1, cnt<=cnt-1, stay.
  - If cnt==0: d<=sgn ? -{1'b0,mag} : {1'b0,mag} (W_D-bit two's complement); nonnorm<=nonnorm_r; out_valid<=1; go to DONE.
- DONE: out_valid=1; d and nonnorm are held stable.
  - On out_ready: out_valid<=0; go to IDLE.
  - A new input is not accepted in the same cycle, because in_ready=0 in DONE.
- Latency: input handshake at edge k gives out_valid high after edge k+e+1. So e=0 takes 1 cycle and e=7 takes 8 cycles. Minimum initiation interval is e+3 cycles.
- Width rule: mag never overflows under legal parameters. No saturation logic.
- Negative zero (s=1, mag=0) yields d=0.
- Input changes while not in IDLE are ignored; latched values are used.
- Back-pressure: out_ready low holds DONE indefinitely with d unchanged.
- Reset mid-SHIFT or mid-DONE: immediate return to reset values; the in-flight result is discarded.
- in_valid asserted during reset: ignored. First accept happens at the first edge after rst deasserts.

Decomposition:
- Shared package/header fpdec_defs holds W_D/W_E/W_F defaults and the state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
- fpcvt uses the same width constants.
- No sub-module: the shifter, counter and negation stay inline in one module.

Test Plan:
- Reset, then s=0 e=0 f=0 with in_valid for 1 cycle -> out_valid 1 cycle later; d=12'h000, nonnorm=0.
- s=0 e=2 f=4'b1010 -> out_valid exactly 3 cycles after accept; d=40 (12'h028), nonnorm=0.
- s=1 e=7 f=15 -> out_valid 8 cycles after accept; d=-1920 (12'h880). Feed fpcvt outputs for d_in=-2048 and confirm d=12'h880.
- s=0 e=3 f=5 -> d=40, nonnorm=1. Then s=1 e=0 f=0 -> d=0, nonnorm=0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> d stable, in_ready=0, extra in_valid pulses ignored. Raise out_ready -> out_valid drops next edge; in_ready=1.
- Start e=7 decode, assert rst 3 cycles in -> d=0, out_valid=0, in_ready=1 immediately. After release, a fresh s=0 e=1 f=8 decodes to d=16.

Source files
------------

// File: rtl/fpdec_pkg.sv
// rtl/fpdec_pkg.sv - shared widths and state encoding for the FP-to-linear decoder
package fpdec_pkg;
    localparam int W_D = 12;
    localparam int W_E = 3;
    localparam int W_F = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/fpdec_if.sv
// rtl/fpdec_if.sv - input and output handshake bundle of the decoder
interface fpdec_if;
    import fpdec_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic           s;
    logic [W_E-1:0] e;
    logic [W_F-1:0] f;
    logic           out_valid;
    logic           out_ready;
    logic [W_D-1:0] d;
    logic           nonnorm;

    modport master (
        output in_valid, s, e, f, out_ready,
        input  in_ready, out_valid, d, nonnorm
    );

    modport slave (
        input  in_valid, s, e, f, out_ready,
        output in_ready, out_valid, d, nonnorm
    );
endinterface

// File: rtl/fpdec.sv
// rtl/fpdec.sv - iterative decoder: d = (s ? -1 : 1) * (f << e), one shift per cycle
module fpdec
    import fpdec_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    fpdec_if.slave io
);

    state_e         state_q, state_d;
    logic [W_D-2:0] mag_q;
    logic [W_E-1:0] cnt_q;
    logic           sgn_q;
    logic           nn_lat_q;
    logic [W_D-1:0] d_q;
    logic           nonnorm_q;
    logic [W_D-1:0] mag_ext;

    assign mag_ext = {1'b0, mag_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.in_valid)     state_d = SHIFT;
            SHIFT:   if (cnt_q == '0)     state_d = DONE;
            DONE:    if (io.out_ready)    state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        io.in_ready  = (state_q == IDLE);
        io.out_valid = (state_q == DONE);
        io.d         = d_q;
        io.nonnorm   = nonnorm_q;
    end

    // mag is sized so the largest legal f << e never reaches the sign bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q     <= '0;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            nn_lat_q  <= 1'b0;
            d_q       <= '0;
            nonnorm_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (io.in_valid) begin
                    sgn_q    <= io.s;
                    mag_q    <= {{(W_D-1-W_F){1'b0}}, io.f};
                    cnt_q    <= io.e;
                    nn_lat_q <= (io.e != '0) && !io.f[W_F-1];
                end
                SHIFT: if (cnt_q != '0) begin
                    mag_q <= mag_q << 1;
                    cnt_q <= cnt_q - W_E'(1);
                end else begin
                    d_q       <= sgn_q ? -mag_ext : mag_ext;
                    nonnorm_q <= nn_lat_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpdec.sv
// tb/tb_fpdec.sv - scoreboard bench for fpdec with directed vectors
module tb_fpdec;
    import fpdec_pkg::*;

    typedef struct {
        logic [W_D-1:0] d;
        logic           nn;
        int             acc;
        int             e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic seen = 1'b0;
    exp_t sb[$];

    fpdec_if io();

    fpdec dut (.clk(clk), .rst(rst), .io(io.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: compares on the first cycle of each out_valid assertion.
    always @(negedge clk) begin
        if (rst) begin
            seen <= 1'b0;
        end else if (io.out_valid && !seen) begin
            seen <= 1'b1;
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("d", int'(io.d), int'(x.d));
                chk("nonnorm", int'(io.nonnorm), int'(x.nn));
                chk("latency", cyc - x.acc, x.e + 1);
            end
        end else if (!io.out_valid) begin
            seen <= 1'b0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!io.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!io.in_ready) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic send(input logic s, input int e, input int f,
                        input logic [W_D-1:0] d, input logic nn, input bit push);
        exp_t x;
        wait_ready();
        io.s = s;
        io.e = W_E'(e);
        io.f = W_F'(f);
        io.in_valid = 1'b1;
        if (push) begin
            x.d = d; x.nn = nn; x.acc = cyc + 1; x.e = e;
            sb.push_back(x);
        end
        @(negedge clk);
        io.in_valid = 1'b0;
        io.s = 1'b0; io.e = '0; io.f = '0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!io.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!io.out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    initial begin
        io.in_valid = 1'b1;
        io.s = 1'b1; io.e = 3'd5; io.f = 4'hF;
        io.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(io.out_valid), 0);
        chk("rst_in_ready", int'(io.in_ready), 1);
        chk("rst_d", int'(io.d), 0);
        chk("rst_nonnorm", int'(io.nonnorm), 0);
        io.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("in_valid_during_rst_ignored", int'(io.in_ready), 1);

        send(1'b0, 0, 0,  12'h000, 1'b0, 1'b1);
        send(1'b0, 2, 10, 12'h028, 1'b0, 1'b1);
        send(1'b1, 7, 15, 12'h880, 1'b0, 1'b1);
        send(1'b0, 3, 5,  12'h028, 1'b1, 1'b1);
        send(1'b1, 0, 0,  12'h000, 1'b0, 1'b1);
        send(1'b1, 4, 9,  12'hF70, 1'b0, 1'b1);
        send(1'b0, 7, 1,  12'h080, 1'b1, 1'b1);

        // Back-pressure: result must hold while extra inputs are ignored.
        wait_ready();
        io.out_ready = 1'b0;
        send(1'b0, 1, 8, 12'h010, 1'b0, 1'b1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            io.in_valid = 1'b1;
            io.s = 1'b1; io.e = 3'd2; io.f = 4'h3;
            @(negedge clk);
            chk("bp_out_valid", int'(io.out_valid), 1);
            chk("bp_d_stable", int'(io.d), 16);
            chk("bp_in_ready", int'(io.in_ready), 0);
        end
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", int'(io.out_valid), 0);
        chk("bp_release_in_ready", int'(io.in_ready), 1);

        // Reset in the middle of a long decode discards it.
        send(1'b1, 7, 15, 12'h880, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_d", int'(io.d), 0);
        chk("midrst_out_valid", int'(io.out_valid), 0);
        chk("midrst_in_ready", int'(io.in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        send(1'b0, 1, 8, 12'h010, 1'b0, 1'b1);

        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
